// File: rtl/instruction_decode.sv
// Decode stage: register file, main control decode, immediate/jump formation, and the
// ID/EX pipeline register with stall and flush.
module instruction_decode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_instruction,
  input  logic [31:0]           if_next_address,
  input  logic                  if_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_reg_write,
  input  logic [4:0]            wb_write_reg,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  id_valid,
  output logic [31:0]           id_next_address,
  output logic [DATA_WIDTH-1:0] id_read_data_1,
  output logic [DATA_WIDTH-1:0] id_read_data_2,
  output logic [31:0]           id_sign_ext_imm,
  output logic [31:0]           id_jump_address,
  output logic [4:0]            id_rs,
  output logic [4:0]            id_rt,
  output logic [4:0]            id_rd,
  output logic [4:0]            id_shamt,
  output logic [5:0]            id_funct,
  output logic                  id_reg_dst,
  output logic                  id_alu_src,
  output logic                  id_mem_to_reg,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  output logic [1:0]            id_alu_op,
  output logic                  id_illegal
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;
  logic [15:0] imm;
  logic [25:0] target;

  assign opcode = if_instruction[31:26];
  assign rs     = if_instruction[25:21];
  assign rt     = if_instruction[20:16];
  assign rd     = if_instruction[15:11];
  assign shamt  = if_instruction[10:6];
  assign funct  = if_instruction[5:0];
  assign imm    = if_instruction[15:0];
  assign target = if_instruction[25:0];

  // Register file
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;

  assign rf_we = wb_reg_write && (wb_write_reg != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[wb_write_reg] <= wb_write_data;
    end
  end

  // Write-first: a same-edge write-back to a source register is forwarded into ID/EX.
  always_comb begin
    rs_data = rf_q[rs];
    if (rs == 5'd0) begin
      rs_data = '0;
    end else if (rf_we && (wb_write_reg == rs)) begin
      rs_data = wb_write_data;
    end
  end

  always_comb begin
    rt_data = rf_q[rt];
    if (rt == 5'd0) begin
      rt_data = '0;
    end else if (rf_we && (wb_write_reg == rt)) begin
      rt_data = wb_write_data;
    end
  end

  // Main control decode
  ctrl_t dec_ctrl;

  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      OpRtype: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = AluFunct;
      end
      OpLw: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.alu_op     = AluAdd;
      end
      OpSw: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = AluAdd;
      end
      OpBeq: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = AluSub;
      end
      OpAddi: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = AluAdd;
      end
      OpJ: begin
        dec_ctrl.jump = 1'b1;
      end
      default: begin
        dec_ctrl.illegal = 1'b1;
      end
    endcase
  end

  // ID/EX pipeline register
  logic                  valid_q,     valid_d;
  logic [31:0]           next_addr_q, next_addr_d;
  logic [DATA_WIDTH-1:0] rd1_q,       rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q,       rd2_d;
  logic [31:0]           imm_q,       imm_d;
  logic [31:0]           jaddr_q,     jaddr_d;
  logic [4:0]            rs_q,        rs_d;
  logic [4:0]            rt_q,        rt_d;
  logic [4:0]            rd_q,        rd_d;
  logic [4:0]            shamt_q,     shamt_d;
  logic [5:0]            funct_q,     funct_d;
  ctrl_t                 ctrl_q,      ctrl_d;

  always_comb begin
    valid_d     = valid_q;
    next_addr_d = next_addr_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    jaddr_d     = jaddr_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    shamt_d     = shamt_q;
    funct_d     = funct_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      // Data fields are don't-care on a bubble; holding them saves toggling.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d     = if_valid;
      next_addr_d = if_next_address;
      rd1_d       = rs_data;
      rd2_d       = rt_data;
      imm_d       = {{16{imm[15]}}, imm};
      jaddr_d     = {if_next_address[31:28], target, 2'b00};
      rs_d        = rs;
      rt_d        = rt;
      rd_d        = rd;
      shamt_d     = shamt;
      funct_d     = funct;
      ctrl_d      = if_valid ? dec_ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      next_addr_q <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      jaddr_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      funct_q     <= '0;
      ctrl_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      next_addr_q <= next_addr_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      jaddr_q     <= jaddr_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      shamt_q     <= shamt_d;
      funct_q     <= funct_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign id_valid        = valid_q;
  assign id_next_address = next_addr_q;
  assign id_read_data_1  = rd1_q;
  assign id_read_data_2  = rd2_q;
  assign id_sign_ext_imm = imm_q;
  assign id_jump_address = jaddr_q;
  assign id_rs           = rs_q;
  assign id_rt           = rt_q;
  assign id_rd           = rd_q;
  assign id_shamt        = shamt_q;
  assign id_funct        = funct_q;
  assign id_reg_dst      = ctrl_q.reg_dst;
  assign id_alu_src      = ctrl_q.alu_src;
  assign id_mem_to_reg   = ctrl_q.mem_to_reg;
  assign id_reg_write    = ctrl_q.reg_write;
  assign id_mem_read     = ctrl_q.mem_read;
  assign id_mem_write    = ctrl_q.mem_write;
  assign id_branch       = ctrl_q.branch;
  assign id_jump         = ctrl_q.jump;
  assign id_alu_op       = ctrl_q.alu_op;
  assign id_illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: a behavioural model checked every cycle, plus hand-computed
// literal expectations on the directed scenarios.
module tb_instruction_decode;

  typedef logic [197:0] vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] if_instruction;
  logic [31:0] if_next_address;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        id_valid;
  logic [31:0] id_next_address;
  logic [31:0] id_read_data_1;
  logic [31:0] id_read_data_2;
  logic [31:0] id_sign_ext_imm;
  logic [31:0] id_jump_address;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic        id_reg_dst;
  logic        id_alu_src;
  logic        id_mem_to_reg;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  logic [1:0]  id_alu_op;
  logic        id_illegal;

  instruction_decode dut (
    .clk             (clk),
    .rst             (rst),
    .if_instruction  (if_instruction),
    .if_next_address (if_next_address),
    .if_valid        (if_valid),
    .stall           (stall),
    .flush           (flush),
    .wb_reg_write    (wb_reg_write),
    .wb_write_reg    (wb_write_reg),
    .wb_write_data   (wb_write_data),
    .id_valid        (id_valid),
    .id_next_address (id_next_address),
    .id_read_data_1  (id_read_data_1),
    .id_read_data_2  (id_read_data_2),
    .id_sign_ext_imm (id_sign_ext_imm),
    .id_jump_address (id_jump_address),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_shamt        (id_shamt),
    .id_funct        (id_funct),
    .id_reg_dst      (id_reg_dst),
    .id_alu_src      (id_alu_src),
    .id_mem_to_reg   (id_mem_to_reg),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_branch       (id_branch),
    .id_jump         (id_jump),
    .id_alu_op       (id_alu_op),
    .id_illegal      (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump
  // alu_op[1:0] illegal
  logic [10:0] dut_ctrl;
  vec_t        dut_vec;
  assign dut_ctrl = {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
                     id_mem_write, id_branch, id_jump, id_alu_op, id_illegal};
  assign dut_vec  = {id_valid, id_next_address, id_read_data_1, id_read_data_2,
                     id_sign_ext_imm, id_jump_address, id_rs, id_rt, id_rd, id_shamt,
                     id_funct, dut_ctrl};

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        e_valid;
  logic [31:0] e_next, e_rd1, e_rd2, e_imm, e_jaddr;
  logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
  logic [5:0]  e_funct;
  logic [10:0] e_ctrl;
  vec_t        exp_vec;
  assign exp_vec = {e_valid, e_next, e_rd1, e_rd2, e_imm, e_jaddr, e_rs, e_rt, e_rd, e_shamt,
                    e_funct, e_ctrl};

  int   checks = 0;
  int   errors = 0;
  logic chk_on = 1'b0;

  string q_name [$];
  int    q_field [$];
  vec_t  q_val [$];

  function automatic logic [10:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'd0:  return 11'b1001_0000_100;
      6'd35: return 11'b0111_1000_000;
      6'd43: return 11'b0100_0100_000;
      6'd4:  return 11'b0000_0010_010;
      6'd8:  return 11'b0101_0000_000;
      6'd2:  return 11'b0000_0001_000;
      default: return 11'b0000_0000_001;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    e_valid = 0; e_next = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_jaddr = 0;
    e_rs = 0; e_rt = 0; e_rd = 0; e_shamt = 0; e_funct = 0; e_ctrl = 0;
  endtask

  // One clock edge of the architectural behaviour: commit write-back, then read.
  task automatic model_step();
    logic signed [15:0] imm16;
    if (rst) begin
      model_reset();
    end else begin
      if (wb_reg_write && wb_write_reg != 0) m_rf[wb_write_reg] = wb_write_data;
      if (flush) begin
        e_valid = 0;
        e_ctrl  = 0;
      end else if (!stall) begin
        imm16   = if_instruction[15:0];
        e_valid = if_valid;
        e_next  = if_next_address;
        e_rd1   = m_rf[if_instruction[25:21]];
        e_rd2   = m_rf[if_instruction[20:16]];
        e_imm   = 32'(imm16);
        e_jaddr = (if_next_address & 32'hF000_0000) | (32'(if_instruction[25:0]) * 4);
        e_rs    = if_instruction[25:21];
        e_rt    = if_instruction[20:16];
        e_rd    = if_instruction[15:11];
        e_shamt = if_instruction[10:6];
        e_funct = if_instruction[5:0];
        e_ctrl  = if_valid ? ctrl_of(if_instruction[31:26]) : 11'd0;
      end
    end
  endtask

  function automatic vec_t get_field(input int f);
    case (f)
      0: return vec_t'(id_valid);
      1: return vec_t'(id_next_address);
      2: return vec_t'(id_read_data_1);
      3: return vec_t'(id_read_data_2);
      4: return vec_t'(id_sign_ext_imm);
      5: return vec_t'(id_jump_address);
      6: return vec_t'(id_rd);
      7: return vec_t'(dut_ctrl);
      default: return dut_vec;
    endcase
  endfunction

  task automatic expect_f(input string name, input int f, input vec_t v);
    q_name.push_back(name);
    q_field.push_back(f);
    q_val.push_back(v);
  endtask

  // Sole owner of the counters: model compare every cycle plus queued literal checks.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h", $time, dut_vec, exp_vec);
      end
      while (q_name.size() > 0) begin
        string n;
        int    f;
        vec_t  v;
        vec_t  a;
        n = q_name.pop_front();
        f = q_field.pop_front();
        v = q_val.pop_front();
        a = get_field(f);
        checks++;
        if (a !== v) begin
          errors++;
          $display("FAIL %s got %h want %h", n, a, v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] nxt, input logic v);
    if_instruction  = instr;
    if_next_address = nxt;
    if_valid        = v;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_reg_write  = en;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; stall = 0; flush = 0;
    drive(32'd0, 32'd0, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    model_reset();
    #2;
    rst = 1;
    model_reset();
    chk_on = 1;
    tick();
    tick();
    expect_f("reset_all", 8, '0);
    rst = 0;

    // Write-back then read: reg8 = 0xAA, then add $9,$8,$8
    wb(1'b1, 5'd8, 32'h0000_00AA);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h0108_4820, 32'h0000_0104, 1'b1);
    tick();
    expect_f("add_valid", 0, vec_t'(1'b1));
    expect_f("add_rd1", 2, vec_t'(32'hAA));
    expect_f("add_rd2", 3, vec_t'(32'hAA));
    expect_f("add_rd", 6, vec_t'(5'd9));
    expect_f("add_ctrl", 7, vec_t'(11'b1001_0000_100));

    // Same-edge bypass on lw
    drive(32'h8D09_FFFC, 32'h0000_0108, 1'b1);
    wb(1'b1, 5'd8, 32'h0000_1234);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    expect_f("lw_rd1", 2, vec_t'(32'h1234));
    expect_f("lw_rd2", 3, vec_t'(32'h0));
    expect_f("lw_imm", 4, vec_t'(32'hFFFF_FFFC));
    expect_f("lw_ctrl", 7, vec_t'(11'b0111_1000_000));

    // $0 write, same edge and afterwards: addi $0,$0,5
    drive(32'h2000_0005, 32'h0000_010C, 1'b1);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    expect_f("r0_bypass_rd1", 2, vec_t'(32'h0));
    tick();
    wb(1'b0, 5'd0, 32'd0);
    expect_f("r0_rd1", 2, vec_t'(32'h0));
    expect_f("r0_rd2", 3, vec_t'(32'h0));
    expect_f("addi_imm", 4, vec_t'(32'h5));
    expect_f("addi_ctrl", 7, vec_t'(11'b0101_0000_000));

    // Stall for 3 cycles with new instructions and a write-back in flight
    drive(32'h1109_0003, 32'h0000_0200, 1'b1);
    tick();
    stall = 1;
    wb(1'b1, 5'd8, 32'h0000_5555);
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 32'h0800_0010 : 32'hAD09_0004, 32'h0000_0300, 1'b1);
      tick();
      expect_f("stall_valid", 0, vec_t'(1'b1));
      expect_f("stall_next", 1, vec_t'(32'h200));
      expect_f("stall_rd1", 2, vec_t'(32'h1234));
      expect_f("stall_ctrl", 7, vec_t'(11'b0000_0010_010));
    end
    stall = 0;
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h0108_4820, 32'h0000_0304, 1'b1);
    tick();
    expect_f("post_stall_rd1", 2, vec_t'(32'h5555));

    // Stall and flush together
    drive(32'hAD09_0004, 32'h0000_0308, 1'b1);
    tick();
    expect_f("sw_ctrl", 7, vec_t'(11'b0100_0100_000));
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    expect_f("flush_valid", 0, vec_t'(1'b0));
    expect_f("flush_ctrl", 7, vec_t'(11'b0));

    // Jump target uses PC+4 upper bits
    drive(32'h0800_0010, 32'h4000_0004, 1'b1);
    tick();
    expect_f("j_addr", 5, vec_t'(32'h4000_0040));
    expect_f("j_ctrl", 7, vec_t'(11'b0000_0001_000));

    // Illegal opcode, then flush clears it
    drive(32'hFC00_0000, 32'h4000_0008, 1'b1);
    tick();
    expect_f("ill_valid", 0, vec_t'(1'b1));
    expect_f("ill_ctrl", 7, vec_t'(11'b0000_0000_001));
    flush = 1;
    tick();
    flush = 0;
    expect_f("ill_flush_ctrl", 7, vec_t'(11'b0));

    // Bubble from fetch carries no control
    drive(32'h8D09_FFFC, 32'h4000_000C, 1'b0);
    tick();
    expect_f("bubble_valid", 0, vec_t'(1'b0));
    expect_f("bubble_ctrl", 7, vec_t'(11'b0));

    // Mid-cycle reset with a live instruction
    drive(32'h0108_4820, 32'h4000_0010, 1'b1);
    tick();
    expect_f("pre_rst_valid", 0, vec_t'(1'b1));
    @(negedge clk);
    @(posedge clk);
    model_step();
    #2;
    rst = 1;
    model_reset();
    expect_f("mid_reset_all", 8, '0);
    tick();
    rst = 0;
    drive(32'h0108_4820, 32'h4000_0014, 1'b1);
    tick();
    expect_f("post_rst_rd1", 2, vec_t'(32'h0));
    drive(32'h0000_0000, 32'h0, 1'b0);
    tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
